// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions used by the fetch stage and the instruction memory.
package kgp_risc_pkg;

    localparam int unsigned SIZE_DEFAULT     = 32;
    localparam int unsigned MEM_SIZE_DEFAULT = 128;

    // Terminator word that ends the program image.
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Fetch-stage control state.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch stage, the instruction memory, execute and decode.
interface instruction_fetch_unit_if
    import kgp_risc_pkg::*;
#(
    parameter int unsigned SIZE = SIZE_DEFAULT
);

    logic [SIZE-1:0] imem_addr;
    logic [SIZE-1:0] imem_data;
    logic            redirect_valid;
    logic [SIZE-1:0] redirect_target;
    logic            inst_ready;
    logic            inst_valid;
    logic [SIZE-1:0] inst_data;
    logic [SIZE-1:0] inst_pc;
    logic            halted;
    logic            fault;
    logic [SIZE-1:0] fetch_count;

    // Fetch unit side.
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_target,
        input  inst_ready,
        output inst_valid,
        output inst_data,
        output inst_pc,
        output halted,
        output fault,
        output fetch_count
    );

    // Environment side: memory, execute and decode.
    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_target,
        output inst_ready,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        input  halted,
        input  fault,
        input  fetch_count
    );

endinterface

// File: rtl/ifid_pipe_reg.sv
// IF/ID holding register: valid/ready slot for an instruction word and its PC.
module ifid_pipe_reg #(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic            ready,
    input  logic [SIZE-1:0] d_data,
    input  logic [SIZE-1:0] d_pc,
    output logic            valid,
    output logic [SIZE-1:0] data,
    output logic [SIZE-1:0] pc
);

    // Flush beats load; an unreplaced slot empties when decode takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            pc    <= d_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// KGP-RISC fetch stage: PC, run/halt/fault control, fetch counter and IF/ID slot.
module instruction_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter int unsigned     SIZE      = SIZE_DEFAULT,
    parameter int unsigned     MEM_SIZE  = MEM_SIZE_DEFAULT,
    parameter logic [SIZE-1:0] RESET_PC  = '0,
    parameter logic [SIZE-1:0] HALT_WORD = SIZE'(HALT_WORD_DEFAULT)
) (
    input  logic                     clka,
    input  logic                     rsta,
    instruction_fetch_unit_if.master bus
);

    localparam logic [SIZE-1:0] MEM_LIMIT = SIZE'(MEM_SIZE);

    fetch_state_t    state;
    logic [SIZE-1:0] pc;
    logic [SIZE-1:0] pc_inc;
    logic [SIZE-1:0] fetch_count;
    logic            redirect_ok;
    logic            stall;
    logic            is_halt_word;
    logic            ifid_flush;
    logic            ifid_load;
    logic            ifid_valid;
    logic [SIZE-1:0] ifid_data;
    logic [SIZE-1:0] ifid_pc;

    assign pc_inc       = pc + SIZE'(1);
    assign redirect_ok  = (bus.redirect_target < MEM_LIMIT);
    assign stall        = ifid_valid && !bus.inst_ready;
    assign is_halt_word = (bus.imem_data == HALT_WORD);

    // Slot control: redirects flush, a halt word drops the slot, otherwise fetch when not stalled.
    always_comb begin
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        case (state)
            RUN: begin
                ifid_flush = bus.redirect_valid || (!stall && is_halt_word);
                ifid_load  = !bus.redirect_valid && !stall && !is_halt_word;
            end
            HALTED:  ifid_flush = bus.redirect_valid;
            default: ifid_flush = 1'b1;
        endcase
    end

    // PC, fetch counter and fetch state.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.redirect_valid) begin
                        if (redirect_ok) pc <= bus.redirect_target;
                        else             state <= FAULT;
                    end else if (!stall) begin
                        if (is_halt_word) begin
                            state <= HALTED;
                        end else begin
                            fetch_count <= fetch_count + SIZE'(1);
                            // Last word of memory: stop with the PC parked on it.
                            if (pc_inc == MEM_LIMIT) state <= HALTED;
                            else                     pc    <= pc_inc;
                        end
                    end
                end
                HALTED: begin
                    if (bus.redirect_valid) begin
                        if (redirect_ok) begin
                            pc    <= bus.redirect_target;
                            state <= RUN;
                        end else begin
                            state <= FAULT;
                        end
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= FAULT;
            endcase
        end
    end

    ifid_pipe_reg #(
        .SIZE (SIZE)
    ) u_ifid (
        .clk    (clka),
        .rst    (rsta),
        .flush  (ifid_flush),
        .load   (ifid_load),
        .ready  (bus.inst_ready),
        .d_data (bus.imem_data),
        .d_pc   (pc),
        .valid  (ifid_valid),
        .data   (ifid_data),
        .pc     (ifid_pc)
    );

    assign bus.imem_addr   = pc;
    assign bus.inst_valid  = ifid_valid;
    assign bus.inst_data   = ifid_data;
    assign bus.inst_pc     = ifid_pc;
    assign bus.halted      = (state == HALTED);
    assign bus.fault       = (state == FAULT);
    assign bus.fetch_count = fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural fetch model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int unsigned MEMN = 128;

    logic clka = 1'b0;
    logic rsta = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:MEMN-1];

    instruction_fetch_unit_if #(.SIZE(32)) bus ();

    instruction_fetch_unit #(
        .SIZE      (32),
        .MEM_SIZE  (128),
        .RESET_PC  (32'd0),
        .HALT_WORD (HALT)
    ) dut (
        .clka (clka),
        .rsta (rsta),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    // Combinational instruction memory.
    assign bus.imem_data = mem[bus.imem_addr[6:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what decode should see, stepped on each clock edge.
    logic [31:0] m_pc, m_data, m_ipc, m_count;
    logic        m_valid, m_halted, m_fault;

    always @(posedge clka or posedge rsta) begin
        if (rsta) begin
            m_pc <= 0; m_data <= 0; m_ipc <= 0; m_count <= 0;
            m_valid <= 0; m_halted <= 0; m_fault <= 0;
        end else if (m_fault) begin
            m_valid <= 0;
        end else if (bus.redirect_valid) begin
            m_valid  <= 0;
            m_halted <= 0;
            if (bus.redirect_target < MEMN) m_pc <= bus.redirect_target;
            else                            m_fault <= 1;
        end else if (m_halted) begin
            if (bus.inst_ready) m_valid <= 0;
        end else if (m_valid && !bus.inst_ready) begin
            // decode not ready: everything holds
        end else if (mem[m_pc[6:0]] == HALT) begin
            m_halted <= 1;
            m_valid  <= 0;
        end else begin
            m_data  <= mem[m_pc[6:0]];
            m_ipc   <= m_pc;
            m_valid <= 1;
            m_count <= m_count + 1;
            if (m_pc + 1 == MEMN) m_halted <= 1;
            else                  m_pc <= m_pc + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clka) begin
        if (rsta === 1'b0) begin
            chk("m_imem_addr", bus.imem_addr, m_pc);
            chk("m_inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_valid});
            chk("m_halted", {31'd0, bus.halted}, {31'd0, m_halted});
            chk("m_fault", {31'd0, bus.fault}, {31'd0, m_fault});
            chk("m_fetch_count", bus.fetch_count, m_count);
            if (m_valid) begin
                chk("m_inst_pc", bus.inst_pc, m_ipc);
                chk("m_inst_data", bus.inst_data, m_data);
            end
        end
    end

    task automatic tick();
        @(posedge clka);
        #2;
    endtask

    task automatic fill(input bit with_halt);
        for (int i = 0; i < MEMN; i++) mem[i] = 32'h1357_0000 + 32'(i) * 3;
        mem[31] = 32'h0800_001A;
        if (with_halt) mem[32] = HALT;
    endtask

    task automatic redirect(input logic v, input logic [31:0] t);
        bus.redirect_valid  = v;
        bus.redirect_target = t;
    endtask

    task automatic expect_slot(input string tag, input logic v, input logic [31:0] ipc,
                               input logic [31:0] cnt, input logic [31:0] addr);
        chk({tag, "_valid"}, {31'd0, bus.inst_valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_pc"}, bus.inst_pc, ipc);
            chk({tag, "_data"}, bus.inst_data, mem[ipc[6:0]]);
        end
        chk({tag, "_count"}, bus.fetch_count, cnt);
        chk({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    task automatic expect_flags(input string tag, input logic h, input logic f);
        chk({tag, "_halted"}, {31'd0, bus.halted}, {31'd0, h});
        chk({tag, "_fault"}, {31'd0, bus.fault}, {31'd0, f});
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd0);
        chk({tag, "_data"}, bus.inst_data, 32'd0);
        chk({tag, "_pc"}, bus.inst_pc, 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, 32'd0);
        chk({tag, "_count"}, bus.fetch_count, 32'd0);
        expect_flags(tag, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        redirect(1'b0, 32'd0);
        bus.inst_ready = 1'b1;
        rsta = 1'b1;
        tick();
        expect_reset("reset");
        rsta = 1'b0;
    endtask

    initial begin
        fill(1'b1);
        redirect(1'b0, 32'd0);
        bus.inst_ready = 1'b1;

        // Straight-line fetch of words 0..4.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_slot("straight", 1'b1, 32'(i), 32'(i + 1), 32'(i + 1));
        end

        // Backpressure with inst_pc=2 held.
        do_reset();
        repeat (3) tick();
        expect_slot("pre_stall", 1'b1, 32'd2, 32'd3, 32'd3);
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_slot("stall", 1'b1, 32'd2, 32'd3, 32'd3);
        end
        bus.inst_ready = 1'b1;
        tick();
        expect_slot("release", 1'b1, 32'd3, 32'd4, 32'd4);
        tick();
        tick();
        expect_slot("run5", 1'b1, 32'd5, 32'd6, 32'd6);

        // Redirect while stalled at inst_pc=5.
        bus.inst_ready = 1'b0;
        tick();
        expect_slot("stall5", 1'b1, 32'd5, 32'd6, 32'd6);
        redirect(1'b1, 32'd1);
        tick();
        expect_slot("redir_flush", 1'b0, 32'd0, 32'd6, 32'd1);
        redirect(1'b0, 32'd0);
        bus.inst_ready = 1'b1;
        tick();
        expect_slot("redir_fetch", 1'b1, 32'd1, 32'd7, 32'd2);

        // Walk up to the terminator; a redirect on the halt-word edge keeps running.
        redirect(1'b1, 32'd28);
        tick();
        redirect(1'b0, 32'd0);
        repeat (4) tick();
        expect_slot("at31", 1'b1, 32'd31, 32'd11, 32'd32);
        redirect(1'b1, 32'd29);
        tick();
        expect_slot("redir_vs_halt", 1'b0, 32'd0, 32'd11, 32'd29);
        expect_flags("redir_vs_halt", 1'b0, 1'b0);
        redirect(1'b0, 32'd0);
        repeat (3) tick();
        expect_slot("again31", 1'b1, 32'd31, 32'd14, 32'd32);
        tick();
        expect_slot("halt", 1'b0, 32'd0, 32'd14, 32'd32);
        expect_flags("halt", 1'b1, 1'b0);
        tick();
        expect_flags("halt_hold", 1'b1, 1'b0);
        redirect(1'b1, 32'd26);
        tick();
        expect_slot("recover", 1'b0, 32'd0, 32'd14, 32'd26);
        expect_flags("recover", 1'b0, 1'b0);
        redirect(1'b0, 32'd0);
        tick();
        expect_slot("recover_fetch", 1'b1, 32'd26, 32'd15, 32'd27);

        // Out-of-range redirect faults and stays faulted.
        redirect(1'b1, 32'd200);
        tick();
        expect_slot("fault", 1'b0, 32'd0, 32'd15, 32'd27);
        expect_flags("fault", 1'b0, 1'b1);
        redirect(1'b1, 32'd3);
        tick();
        expect_slot("fault_sticky", 1'b0, 32'd0, 32'd15, 32'd27);
        expect_flags("fault_sticky", 1'b0, 1'b1);
        redirect(1'b0, 32'd0);
        repeat (2) tick();
        expect_flags("fault_hold", 1'b0, 1'b1);

        // Run off the end of memory with no terminator.
        fill(1'b0);
        do_reset();
        repeat (128) tick();
        expect_slot("eom", 1'b1, 32'd127, 32'd128, 32'd127);
        expect_flags("eom", 1'b1, 1'b0);
        tick();
        expect_slot("eom_drain", 1'b0, 32'd0, 32'd128, 32'd127);
        expect_flags("eom_drain", 1'b1, 1'b0);

        // Asynchronous reset between edges.
        fill(1'b1);
        do_reset();
        repeat (3) tick();
        expect_slot("pre_areset", 1'b1, 32'd2, 32'd3, 32'd3);
        rsta = 1'b1;
        #1;
        expect_reset("areset");
        #1;
        rsta = 1'b0;
        tick();
        expect_slot("post_areset", 1'b1, 32'd0, 32'd1, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end fetch stage of the KGP-RISC pipeline. Holds the program counter and drives the word address into the combinational-read instruction memory. Captures the returned instruction into the IF/ID register and presents it to decode over a valid/ready handshake. Also handles redirects from execute (branch/jump), halting on the all-ones terminator word, and out-of-range faults.

Parameters:
SIZE, 32, data and address width; matches the instruction memory.
MEM_SIZE, 128, instruction memory depth in words; legal PC range is 0..MEM_SIZE-1.
RESET_PC, 0, PC value loaded on reset.
HALT_WORD, 32'hFFFF_FFFF, encoding that terminates the program image.

Ports:
clka  input  1  clock; all state updates on the rising edge.
rsta  input  1  reset; asynchronous, active-high.
imem_addr  output  SIZE  word address to instruction memory; equals the PC register (combinational).
imem_data  input  SIZE  instruction word returned combinationally for imem_addr.
redirect_valid  input  1  execute-stage branch/jump taken this cycle.
redirect_target  input  SIZE  absolute word address of the redirect.
inst_ready  input  1  decode can accept inst_data this cycle.
inst_valid  output  1  IF/ID register holds a valid instruction.
inst_data  output  SIZE  IF/ID instruction word.
inst_pc  output  SIZE  word address inst_data was fetched from.
halted  output  1  fetch stopped on HALT_WORD or end of memory.
fault  output  1  sticky; redirect target was out of range.
fetch_count  output  SIZE  number of instructions accepted into IF/ID since reset; wraps modulo 2^SIZE.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): pc=RESET_PC, state=RUN, inst_valid=0, inst_data=0, inst_pc=0, halted=0, fault=0, fetch_count=0.
- States are RUN, HALTED and FAULT. halted = (state==HALTED); fault = (state==FAULT).
- Per-edge priority in RUN, highest first:
  1. redirect_valid: if redirect_target < MEM_SIZE, pc<=redirect_target, else state<=FAULT. inst_valid<=0 (flush); this wins over a stall.
  2. Stall when inst_valid && !inst_ready: pc, inst_* and fetch_count hold.
  3. Halt when imem_data==HALT_WORD: state<=HALTED, inst_valid<=0, pc holds.
  4. Otherwise: inst_data<=imem_data, inst_pc<=pc, inst_valid<=1, fetch_count+=1. pc<=pc+1; if pc+1==MEM_SIZE, also state<=HALTED with pc held at MEM_SIZE-1.
- A slot with inst_valid=0, or one being consumed (inst_ready=1), always allows a new fetch on the same edge. Sustained throughput is 1 instruction/cycle.
- Latency: instruction at address A appears on inst_data one edge after pc==A.
- HALTED: no fetch, and inst_valid drops once any held instruction is consumed. A valid redirect returns to RUN with pc<=target. This recovers speculative halts, e.g. the terminator fetched just past a backward jump. An out-of-range redirect enters FAULT.
- FAULT: sticky until rsta. No fetch, inst_valid=0, redirects ignored.
- Redirect and halt-word on the same edge: redirect wins and state stays RUN.
- imem_addr is never driven ≥ MEM_SIZE.

Decomposition:
- Shared package (kgp_risc_pkg): fetch state enum {RUN, HALTED, FAULT}, HALT_WORD constant, SIZE/MEM_SIZE defaults shared with the instruction memory.
- One natural sub-module: ifid_pipe_reg. It is the valid/ready holding register for inst_data and inst_pc with flush and load inputs. The PC, FSM and counter stay in the top module.

Test Plan:
- Straight-line fetch: memory words 0..4 = distinct non-halt values, inst_ready=1 → inst_pc 0,1,2,3,4 on consecutive cycles, fetch_count=5 after 5 edges.
- Backpressure: inst_ready=0 for 3 cycles with inst_pc=2 valid → inst_pc/inst_data/imem_addr=3 stay stable, fetch_count unchanged; release → inst_pc=3 next edge.
- Redirect during stall: stalled at inst_pc=5, redirect_valid=1, target=1 → inst_valid=0 next edge, then inst_pc=1 the edge after; the held instruction is never counted twice.
- Halt and recovery: word 32=HALT_WORD, word 31=jump → after fetching 31, halted=1, inst_valid=0. Redirect to 26 → halted=0, inst_pc=26 next edge.
- Fault and end-of-memory: redirect_target=200 with MEM_SIZE=128 → fault=1, sticky across further redirects. A separate run reaching pc=127 with no halt word → halted=1, imem_addr=127.
- Async reset mid-run: assert rsta between edges while inst_valid=1 → all outputs reset immediately without a clock; first edge after deassert fetches RESET_PC.
